// File: rtl/restador_serial_pkg.sv
// paquete_aritmetica: shared state encoding and default width for the serial arithmetic blocks
package paquete_aritmetica;
    localparam int N_DEF = 8;
    typedef enum logic [1:0] {REPOSO = 2'd0, RESTA = 2'd1, FIN = 2'd2} estado_t;
endpackage

// File: rtl/restador_serial_if.sv
// restador_serial_if: start/busy/done handshake plus operands and result of the serial subtractor
interface restador_serial_if
    import paquete_aritmetica::*;
#(parameter int N = N_DEF);
    logic         inicio;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ocupado;
    logic         hecho;
    logic [N-1:0] D;
    logic         Bs;
    modport master (output inicio, A, B, input ocupado, hecho, D, Bs);
    modport slave  (input inicio, A, B, output ocupado, hecho, D, Bs);
endinterface

// File: rtl/restador_serial_completo.sv
// restador_completo: 1-bit full subtractor made of two half subtractors and an OR
module restador_completo (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);
    logic d1, bw1, bw2;
    assign d1     = a ^ b;
    assign bw1    = ~a & b;
    assign d      = d1 ^ bw_in;
    assign bw2    = ~d1 & bw_in;
    assign bw_out = bw1 | bw2;
endmodule

// File: rtl/restador_serial.sv
// restador_serial: bit-serial D = A - B, LSB first, one bit per clock with a borrow flip-flop
module restador_serial
    import paquete_aritmetica::*;
#(parameter int N = N_DEF) (
    input logic               clk,
    input logic               rst_n,
    restador_serial_if.slave  bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);
    estado_t       estado, siguiente;
    logic [N-1:0]  reg_a, reg_b, res, d_q;
    logic          borrow, bs_q;
    logic [CW-1:0] cnt;
    logic          d_bit, bw_next, carga, ultimo;
    restador_completo u_rc (
        .a      (reg_a[0]),
        .b      (reg_b[0]),
        .bw_in  (borrow),
        .d      (d_bit),
        .bw_out (bw_next)
    );
    // a start is accepted in REPOSO and FIN, never while subtracting
    assign carga  = bus.inicio && estado != RESTA;
    assign ultimo = estado == RESTA && cnt == ULTIMO;
    assign bus.D  = d_q;
    assign bus.Bs = bs_q;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= REPOSO;
        else        estado <= siguiente;
    end
    // next state: RESTA runs N bits then FIN; REPOSO and FIN both start on inicio
    always_comb begin
        siguiente = (estado == RESTA) ? (ultimo ? FIN : RESTA) : (bus.inicio ? RESTA : REPOSO);
    end
    // handshake outputs decoded from the state
    always_comb begin
        bus.ocupado = estado == RESTA;
        bus.hecho   = estado == FIN;
    end
    // serial datapath; D/Bs update only on the last bit so partial results never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a  <= '0;
            reg_b  <= '0;
            res    <= '0;
            d_q    <= '0;
            borrow <= 1'b0;
            bs_q   <= 1'b0;
            cnt    <= '0;
        end else if (carga) begin
            reg_a  <= bus.A;
            reg_b  <= bus.B;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (estado == RESTA) begin
            reg_a  <= reg_a >> 1;
            reg_b  <= reg_b >> 1;
            res    <= {d_bit, res[N-1:1]};
            borrow <= bw_next;
            cnt    <= ultimo ? cnt : cnt + 1'b1;
            if (ultimo) begin
                d_q  <= {d_bit, res[N-1:1]};
                bs_q <= bw_next;
            end
        end
    end
endmodule

// File: tb/tb_restador_serial.sv
// tb_restador_serial: table vectors, corner sequences and random sweep with a result scoreboard
module tb_restador_serial;
    import paquete_aritmetica::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    restador_serial_if #(.N(8))  bus ();
    restador_serial_if #(.N(16)) bus16 ();

    restador_serial #(.N(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    restador_serial #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
    } vec_t;

    vec_t       tabla[4];
    logic [8:0] sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pop_cmp(input string name);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected hecho got %h expected none", name, {bus.Bs, bus.D});
        end else begin
            chk(name, 32'({bus.Bs, bus.D}), 32'(sb.pop_front()));
        end
    endtask

    task automatic wait_done(input string name, output int busy);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.hecho) begin
                chk({name, " ocupado_en_hecho"}, 32'(bus.ocupado), 32'd0);
                pop_cmp(name);
                return;
            end
            busy += int'(bus.ocupado);
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s timeout got no hecho expected hecho within 40 cycles", name);
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        @(negedge clk);
        bus.inicio = 1'b1;
        bus.A      = a;
        bus.B      = b;
        sb.push_back(exp);
        @(negedge clk);
        bus.inicio = 1'b0;
        bus.A      = 8'($urandom);
        bus.B      = 8'($urandom);
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        int busy;
        start(a, b, exp);
        wait_done(name, busy);
        chk({name, " ciclos_ocupado"}, 32'(busy), 32'd8);
    endtask

    task automatic no_hecho(input string name, input int ncyc);
        int seen = 0;
        repeat (ncyc) begin
            @(negedge clk);
            seen |= int'(bus.hecho);
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int busy;
        int prev;
        int got16;
        logic [7:0] ra, rb;
        bus.inicio = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus16.inicio = 1'b0;
        bus16.A = '0;
        bus16.B = '0;
        tabla[0] = '{8'h5A, 8'h23, 9'h037};
        tabla[1] = '{8'h10, 8'h20, 9'h1F0};
        tabla[2] = '{8'h00, 8'h01, 9'h1FF};
        tabla[3] = '{8'hFF, 8'hFF, 9'h000};

        repeat (2) @(negedge clk);
        chk("reset ocupado", 32'(bus.ocupado), 32'd0);
        chk("reset hecho", 32'(bus.hecho), 32'd0);
        chk("reset D", 32'(bus.D), 32'd0);
        chk("reset Bs", 32'(bus.Bs), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_op("tabla", tabla[i].a, tabla[i].b, tabla[i].exp);

        start(8'h80, 8'h01, 9'h07F);
        repeat (2) @(negedge clk);
        bus.inicio = 1'b1;
        bus.A = 8'h00;
        bus.B = 8'h00;
        chk("ignorado ocupado", 32'(bus.ocupado), 32'd1);
        @(negedge clk);
        bus.inicio = 1'b0;
        wait_done("ignorado", busy);
        chk("ignorado ciclos_ocupado", 32'(busy), 32'd5);
        no_hecho("ignorado sin_segundo_hecho", 12);

        @(negedge clk);
        bus.inicio = 1'b1;
        bus.A = 8'h05;
        bus.B = 8'h03;
        repeat (3) sb.push_back(9'h002);
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            wait_done("continuo", busy);
            if (j > 0) chk("continuo periodo", 32'(cyc - prev), 32'd9);
            prev = cyc;
            if (j < 2) @(negedge clk);
            else bus.inicio = 1'b0;
        end
        @(negedge clk);
        chk("continuo parado", 32'(bus.ocupado), 32'd0);

        start(8'h33, 8'h11, 9'h022);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async ocupado", 32'(bus.ocupado), 32'd0);
        chk("reset_async hecho", 32'(bus.hecho), 32'd0);
        chk("reset_async D", 32'(bus.D), 32'd0);
        chk("reset_async Bs", 32'(bus.Bs), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        no_hecho("reset_async sin_hecho", 12);
        run_op("tras_reset", 8'h33, 8'h11, 9'h022);

        repeat (1500) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("aleatorio", ra, rb, 9'({1'b0, ra} - {1'b0, rb}));
        end

        @(negedge clk);
        bus16.inicio = 1'b1;
        bus16.A = 16'h1234;
        bus16.B = 16'h4321;
        @(negedge clk);
        bus16.inicio = 1'b0;
        got16 = 0;
        for (int i = 0; i < 40 && got16 == 0; i++) begin
            if (bus16.hecho) begin
                got16 = 1;
                chk("n16 resultado", 32'({bus16.Bs, bus16.D}), 32'h1CF13);
            end else begin
                @(negedge clk);
            end
        end
        if (got16 == 0) begin
            checks++;
            errors++;
            $display("FAIL n16 timeout got no hecho expected hecho within 40 cycles");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
